simd_issue_unit: RTL and testbench
==================================

// Module: simd_issue_unit
// PURPOSE
//  Producer side of the SIMD lane instruction interface. Buffers decoded instructions (valid/ready in).
//  Replays each instruction once per thread (tIdx 0..NUM_THREADS-1) onto the lane's field inputs.
//  Inserts bubbles on per-thread RAW hazards, since the lane has no forwarding. Sits between decode and lane(s).
// PARAMETERS
//  NUM_THREADS    4  threads per instruction; legal 1..16
//  FIFO_DEPTH     4  instruction buffer entries; power of 2, >=2
//  HAZARD_WINDOW  3  non-stalled edges from issue until the lane regfile write is visible
// PORTS
//  clk          in   1   clock
//  reset        in   1   synchronous, active-high
//  in_valid     in   1   instruction offered
//  in_ready     out  1   buffer can accept
//  in_funct4    in   5   op; bit4=1 selects IMM as op2
//  in_imm       in   32  immediate
//  in_rs1/rs2/rd in  5   register addresses (x0 never written)
//  in_is_int    in   1   ALU op
//  in_is_float  in   1   FPU op
//  in_we3       in   1   writes rd
//  in_pred_en   in   1   predicated op
//  in_bidx      in   32  block index
//  stall        in   1   global stall (same net as lane stall)
//  tIdx         out  4   issued thread
//  bIdx,IMM     out  32  issued fields
//  FUNCT4       out  5
//  rs1,rs2,rd   out  5
//  is_int,is_float,WE3,pred_en  out 1
//  busy         out  1   buffer non-empty or any scoreboard entry valid
//  hazard_bubbles out 32 bubble counter (see CONFIGURATION)
// BEHAVIOUR
//  - All lane-facing outputs are flops. Reset: all 0, i.e. a bubble (is_int=is_float=WE3=pred_en=0). in_ready=0 during reset, 1 after.
//  - FIFO: push on in_valid&&in_ready. in_ready = !full, independent of in_valid and of a same-cycle pop.
//    Head is read combinationally. Pointers wrap mod FIFO_DEPTH.
//  - FSM: IDLE (FIFO empty or head unissued) / ISSUE (thread counter tc running).
//    - IDLE->ISSUE when FIFO is non-empty.
//    - ISSUE: each non-stalled edge with no hazard loads the head fields with tIdx=tc, then tc++.
//    - After tc=NUM_THREADS-1 issues: pop the head, tc=0. Stay in ISSUE if a next entry exists, else go to IDLE.
//  - Latency: instruction accepted at edge E into an empty IDLE unit -> thread 0 on outputs after edge E+1.
//    With NUM_THREADS=4 and no stall, threads follow at E+2, E+3, E+4.
//  - Bubble: when no issue occurs at an un-stalled edge, outputs load a bubble. Field values are don't-care except that the control bits are 0.
//  - stall=1: outputs, tc, FSM and scoreboard hold. FIFO push is still allowed.
//  - Scoreboard: HAZARD_WINDOW-deep shift register of {valid, tIdx, rd}. It shifts on each non-stalled edge.
//    The issued op enters with valid=WE3&&(rd!=0); a bubble enters valid=0.
//  - Hazard: a valid entry with the same tIdx and rd==head.rs1, or rd==head.rs2 when funct4[4]==0.
//    The issue is blocked and a bubble is emitted. The min same-thread dependent spacing is HAZARD_WINDOW+1 edges.
//  - NUM_THREADS>=HAZARD_WINDOW+1 never produces hazard bubbles.
//  - reset mid-operation: FIFO flushed, scoreboard cleared, tc=0, IDLE, bubble on outputs.
// CONFIGURATION
//  SIMD_ISSUE_PERF_CNT_EN defined:
//    - hazard_bubbles counts non-stalled edges where a bubble was emitted with FIFO non-empty.
//    - The count saturates at 32'hFFFF_FFFF and is cleared by reset.
//  Not defined: hazard_bubbles tied to 0, no counter flops.
// TESTING
//  1 reset -> all outputs 0, busy=0, in_ready=1 on first edge after reset drops
//  2 NUM_THREADS=4: push ADDI rd=3 rs1=1 imm=5 -> tIdx 0,1,2,3 on 4 consecutive cycles, identical fields, then bubble, busy=0
//  3 NUM_THREADS=2: push rd=5 then rs1=5 back-to-back -> instr1 tIdx0 issues after exactly 2 bubbles; instr1 tIdx1 follows with no bubble; hazard_bubbles=2 with macro
//  4 rd=0 producer then rs1=0 consumer, NUM_THREADS=2 -> no bubbles; FUNCT4[4]=1 consumer matching rs2 only -> no bubbles
//  5 stall=1 for 3 cycles mid-thread-2 -> outputs frozen at tIdx=2, then tIdx=3 one edge after release; FIFO push during stall accepted
//  6 push 4 instrs while stall held, FIFO_DEPTH=4 -> in_ready=0 after 4th push; release -> 16 issues in order; reset at issue 7 -> bubble, busy=0

Source files
------------

// File: rtl/simd_issue_unit.sv
// SIMD issue unit: buffers decoded instructions and replays each one once per thread onto the lane,
// inserting bubbles on per-thread RAW hazards. Optional hazard-bubble counter: SIMD_ISSUE_PERF_CNT_EN.
module simd_issue_unit #(
    parameter int NUM_THREADS   = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int HAZARD_WINDOW = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_funct4,
    input  logic [31:0] in_imm,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [4:0]  in_rd,
    input  logic        in_is_int,
    input  logic        in_is_float,
    input  logic        in_we3,
    input  logic        in_pred_en,
    input  logic [31:0] in_bidx,
    input  logic        stall,
    output logic [3:0]  tIdx,
    output logic [31:0] bIdx,
    output logic [31:0] IMM,
    output logic [4:0]  FUNCT4,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        is_int,
    output logic        is_float,
    output logic        WE3,
    output logic        pred_en,
    output logic        busy,
    output logic [31:0] hazard_bubbles
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [4:0]  funct4;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        is_int;
        logic        is_float;
        logic        we3;
        logic        pred_en;
        logic [31:0] bidx;
    } instr_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] tidx;
        logic [4:0] rd;
    } sb_entry_t;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    instr_t    mem [FIFO_DEPTH];
    instr_t    in_instr;
    instr_t    head;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] fill;
    logic      empty;
    logic      full;
    logic      push;
    logic      pop;

    state_t    state;
    state_t    state_nxt;
    logic [3:0] tc;
    logic [3:0] tc_nxt;
    logic      issue;
    logic      hazard;
    logic      last_thread;

    sb_entry_t sb [HAZARD_WINDOW];
    logic      sb_any_valid;

    // ------------------------------------------------------------------
    // Instruction buffer
    // ------------------------------------------------------------------
    always_comb begin
        in_instr = '{funct4:   in_funct4,
                     imm:      in_imm,
                     rs1:      in_rs1,
                     rs2:      in_rs2,
                     rd:       in_rd,
                     is_int:   in_is_int,
                     is_float: in_is_float,
                     we3:      in_we3,
                     pred_en:  in_pred_en,
                     bidx:     in_bidx};
    end

    assign fill     = wr_ptr - rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready = !reset && !full;
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr[AW-1:0]];

    // NOTE: storage carries no reset; an entry is only ever read after it was written,
    // and keeping reset off the array lets it map onto plain RAM/flops without a reset tree.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_instr;
        end
    end

    // NOTE: every clocked process uses non-blocking assignments so all flops sample
    // pre-edge values regardless of process order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Hazard detection against in-flight writes of the same thread
    // ------------------------------------------------------------------
    always_comb begin
        hazard       = 1'b0;
        sb_any_valid = 1'b0;
        for (int i = 0; i < HAZARD_WINDOW; i++) begin
            sb_any_valid = sb_any_valid | sb[i].valid;
            if (sb[i].valid && (sb[i].tidx == tc) &&
                ((sb[i].rd == head.rs1) || (!head.funct4[4] && (sb[i].rd == head.rs2)))) begin
                hazard = 1'b1;
            end
        end
    end

    assign last_thread = (tc == 4'(NUM_THREADS - 1));
    assign busy        = !empty || sb_any_valid;

    // ------------------------------------------------------------------
    // Issue FSM (IDLE issues thread 0 on the same edge it leaves)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            tc    <= '0;
        end else begin
            state <= state_nxt;
            tc    <= tc_nxt;
        end
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        tc_nxt    = tc;
        issue     = 1'b0;
        pop       = 1'b0;
        if (!stall) begin
            issue = !empty && !hazard;
            case (state)
                IDLE:    state_nxt = empty ? IDLE : ISSUE;
                ISSUE:   state_nxt = empty ? IDLE : ISSUE;
                default: state_nxt = IDLE;
            endcase
            if (issue) begin
                if (last_thread) begin
                    tc_nxt    = '0;
                    pop       = 1'b1;
                    state_nxt = (fill > (AW+1)'(1)) ? ISSUE : IDLE;
                end else begin
                    tc_nxt    = tc + 1'b1;
                    state_nxt = ISSUE;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard: one entry per non-stalled edge, oldest drops out
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < HAZARD_WINDOW; i++) begin
                sb[i] <= '0;
            end
        end else if (!stall) begin
            sb[0] <= '{valid: issue && head.we3 && (head.rd != 5'd0),
                       tidx:  tc,
                       rd:    head.rd};
            for (int i = 1; i < HAZARD_WINDOW; i++) begin
                sb[i] <= sb[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Lane-facing output register; a bubble clears every field
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset || (!stall && !issue)) begin
            tIdx     <= '0;
            bIdx     <= '0;
            IMM      <= '0;
            FUNCT4   <= '0;
            rs1      <= '0;
            rs2      <= '0;
            rd       <= '0;
            is_int   <= 1'b0;
            is_float <= 1'b0;
            WE3      <= 1'b0;
            pred_en  <= 1'b0;
        end else if (!stall) begin
            tIdx     <= tc;
            bIdx     <= head.bidx;
            IMM      <= head.imm;
            FUNCT4   <= head.funct4;
            rs1      <= head.rs1;
            rs2      <= head.rs2;
            rd       <= head.rd;
            is_int   <= head.is_int;
            is_float <= head.is_float;
            WE3      <= head.we3;
            pred_en  <= head.pred_en;
        end
    end

`ifdef SIMD_ISSUE_PERF_CNT_EN
    logic [31:0] bubble_cnt;

    // Counts bubbles emitted while work was waiting; saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt <= '0;
        end else if (!stall && !empty && !issue && (bubble_cnt != 32'hFFFF_FFFF)) begin
            bubble_cnt <= bubble_cnt + 32'd1;
        end
    end

    assign hazard_bubbles = bubble_cnt;
`else
    assign hazard_bubbles = '0;
`endif

endmodule

// File: tb/tb_simd_issue_unit.sv
// Directed self-checking bench for simd_issue_unit: a 4-thread instance and a 2-thread instance
// share field inputs, stall and reset; each has its own in_valid.
module tb_simd_issue_unit;

`ifdef SIMD_ISSUE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        va, vb;
    logic [4:0]  f_funct4;
    logic [31:0] f_imm;
    logic [4:0]  f_rs1, f_rs2, f_rd;
    logic        f_is_int, f_is_float, f_we3, f_pred_en;
    logic [31:0] f_bidx;

    logic        a_ready, a_is_int, a_is_float, a_we3, a_pred_en, a_busy;
    logic [3:0]  a_tidx;
    logic [31:0] a_bidx, a_imm, a_hb;
    logic [4:0]  a_funct4, a_rs1, a_rs2, a_rd;

    logic        b_ready, b_is_int, b_is_float, b_we3, b_pred_en, b_busy;
    logic [3:0]  b_tidx;
    logic [31:0] b_bidx, b_imm, b_hb;
    logic [4:0]  b_funct4, b_rs1, b_rs2, b_rd;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    simd_issue_unit #(.NUM_THREADS(4), .FIFO_DEPTH(4), .HAZARD_WINDOW(3)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(va), .in_ready(a_ready),
        .in_funct4(f_funct4), .in_imm(f_imm), .in_rs1(f_rs1), .in_rs2(f_rs2), .in_rd(f_rd),
        .in_is_int(f_is_int), .in_is_float(f_is_float), .in_we3(f_we3), .in_pred_en(f_pred_en),
        .in_bidx(f_bidx), .stall(stall),
        .tIdx(a_tidx), .bIdx(a_bidx), .IMM(a_imm), .FUNCT4(a_funct4),
        .rs1(a_rs1), .rs2(a_rs2), .rd(a_rd),
        .is_int(a_is_int), .is_float(a_is_float), .WE3(a_we3), .pred_en(a_pred_en),
        .busy(a_busy), .hazard_bubbles(a_hb)
    );

    simd_issue_unit #(.NUM_THREADS(2), .FIFO_DEPTH(4), .HAZARD_WINDOW(3)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(vb), .in_ready(b_ready),
        .in_funct4(f_funct4), .in_imm(f_imm), .in_rs1(f_rs1), .in_rs2(f_rs2), .in_rd(f_rd),
        .in_is_int(f_is_int), .in_is_float(f_is_float), .in_we3(f_we3), .in_pred_en(f_pred_en),
        .in_bidx(f_bidx), .stall(stall),
        .tIdx(b_tidx), .bIdx(b_bidx), .IMM(b_imm), .FUNCT4(b_funct4),
        .rs1(b_rs1), .rs2(b_rs2), .rd(b_rd),
        .is_int(b_is_int), .is_float(b_is_float), .WE3(b_we3), .pred_en(b_pred_en),
        .busy(b_busy), .hazard_bubbles(b_hb)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // ctl = {is_int, is_float, we3, pred_en}
    task automatic set_instr(input logic [4:0] funct4, input logic [31:0] imm, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [4:0] rd, input logic [3:0] ctl,
                             input logic [31:0] bidx);
        f_funct4 = funct4;
        f_imm    = imm;
        f_rs1    = rs1;
        f_rs2    = rs2;
        f_rd     = rd;
        {f_is_int, f_is_float, f_we3, f_pred_en} = ctl;
        f_bidx   = bidx;
    endtask

    task automatic check_a(input string tag, input logic [3:0] tidx, input logic [31:0] imm,
                           input logic [4:0] rd, input logic [3:0] ctl);
        check({tag, ".tidx"}, 32'(a_tidx), 32'(tidx));
        check({tag, ".imm"}, a_imm, imm);
        check({tag, ".rd"}, 32'(a_rd), 32'(rd));
        check({tag, ".ctl"}, 32'({a_is_int, a_is_float, a_we3, a_pred_en}), 32'(ctl));
    endtask

    task automatic check_b(input string tag, input logic [3:0] tidx, input logic [31:0] imm,
                           input logic [4:0] rd, input logic [3:0] ctl);
        check({tag, ".tidx"}, 32'(b_tidx), 32'(tidx));
        check({tag, ".imm"}, b_imm, imm);
        check({tag, ".rd"}, 32'(b_rd), 32'(rd));
        check({tag, ".ctl"}, 32'({b_is_int, b_is_float, b_we3, b_pred_en}), 32'(ctl));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        va    = 1'b0;
        vb    = 1'b0;
        set_instr(5'd0, 32'd0, 5'd0, 5'd0, 5'd0, 4'b0000, 32'd0);

        // 1: reset state, then ready on the first edge after reset drops
        step();
        step();
        check("rst.ready_a", 32'(a_ready), 32'd0);
        check("rst.ready_b", 32'(b_ready), 32'd0);
        check_a("rst.a", 4'd0, 32'd0, 5'd0, 4'b0000);
        check("rst.bidx_a", a_bidx, 32'd0);
        check("rst.busy_a", 32'(a_busy), 32'd0);
        check("rst.hb_a", a_hb, 32'd0);
        reset = 1'b0;
        step();
        check("post.ready_a", 32'(a_ready), 32'd1);
        check("post.ready_b", 32'(b_ready), 32'd1);
        check("post.busy_a", 32'(a_busy), 32'd0);
        check_b("post.b", 4'd0, 32'd0, 5'd0, 4'b0000);

        // 2: 4 threads replay ADDI rd=3 rs1=1 imm=5
        set_instr(5'b10000, 32'd5, 5'd1, 5'd0, 5'd3, 4'b1010, 32'd7);
        va = 1'b1;
        step();
        va = 1'b0;
        check("t2.accept_busy", 32'(a_busy), 32'd1);
        check("t2.accept_bubble", 32'(a_is_int), 32'd0);
        for (int t = 0; t < 4; t++) begin
            step();
            check_a($sformatf("t2.thr%0d", t), 4'(t), 32'd5, 5'd3, 4'b1010);
            check($sformatf("t2.thr%0d.bidx", t), a_bidx, 32'd7);
            check($sformatf("t2.thr%0d.f4", t), 32'(a_funct4), 32'h10);
            check($sformatf("t2.thr%0d.rs1", t), 32'(a_rs1), 32'd1);
        end
        step();
        check("t2.bubble.ctl", 32'({a_is_int, a_is_float, a_we3, a_pred_en}), 32'd0);
        step();
        step();
        check("t2.idle_busy", 32'(a_busy), 32'd0);
        check("t2.hb", a_hb, 32'd0);

        // 3: 2 threads, rd=5 producer then rs1=5 consumer back-to-back
        set_instr(5'd0, 32'h11, 5'd1, 5'd2, 5'd5, 4'b1010, 32'd0);
        vb = 1'b1;
        step();
        set_instr(5'd0, 32'h22, 5'd5, 5'd7, 5'd6, 4'b1010, 32'd0);
        step();
        vb = 1'b0;
        check_b("t3.p0", 4'd0, 32'h11, 5'd5, 4'b1010);
        step();
        check_b("t3.p1", 4'd1, 32'h11, 5'd5, 4'b1010);
        step();
        check("t3.bub1", 32'(b_is_int), 32'd0);
        step();
        check("t3.bub2", 32'(b_is_int), 32'd0);
        step();
        check_b("t3.c0", 4'd0, 32'h22, 5'd6, 4'b1010);
        step();
        check_b("t3.c1", 4'd1, 32'h22, 5'd6, 4'b1010);
        check("t3.hb", b_hb, PERF ? 32'd2 : 32'd0);
        step();
        check("t3.drain", 32'(b_is_int), 32'd0);
        check("t3.hb_hold", b_hb, PERF ? 32'd2 : 32'd0);

        // 4a: rd=0 producer, rs1=0 consumer -> no bubbles
        set_instr(5'd0, 32'h31, 5'd1, 5'd2, 5'd0, 4'b1010, 32'd0);
        vb = 1'b1;
        step();
        set_instr(5'd0, 32'h32, 5'd0, 5'd0, 5'd8, 4'b1010, 32'd0);
        step();
        vb = 1'b0;
        check_b("t4a.p0", 4'd0, 32'h31, 5'd0, 4'b1010);
        step();
        check_b("t4a.p1", 4'd1, 32'h31, 5'd0, 4'b1010);
        step();
        check_b("t4a.c0", 4'd0, 32'h32, 5'd8, 4'b1010);
        step();
        check_b("t4a.c1", 4'd1, 32'h32, 5'd8, 4'b1010);

        // 4b: immediate-form consumer matches producer rd only through rs2 -> no bubbles
        set_instr(5'd0, 32'h41, 5'd1, 5'd2, 5'd9, 4'b1010, 32'd0);
        vb = 1'b1;
        step();
        set_instr(5'b10001, 32'h42, 5'd3, 5'd9, 5'd4, 4'b0110, 32'd0);
        step();
        vb = 1'b0;
        check_b("t4b.p0", 4'd0, 32'h41, 5'd9, 4'b1010);
        step();
        check_b("t4b.p1", 4'd1, 32'h41, 5'd9, 4'b1010);
        step();
        check_b("t4b.c0", 4'd0, 32'h42, 5'd4, 4'b0110);
        step();
        check_b("t4b.c1", 4'd1, 32'h42, 5'd4, 4'b0110);
        check("t4.hb", b_hb, PERF ? 32'd2 : 32'd0);

        // 5: stall for 3 edges while thread 2 is on the outputs; push during stall
        set_instr(5'd2, 32'h55, 5'd1, 5'd2, 5'd10, 4'b1011, 32'd3);
        va = 1'b1;
        step();
        va = 1'b0;
        step();
        step();
        step();
        check_a("t5.thr2", 4'd2, 32'h55, 5'd10, 4'b1011);
        stall = 1'b1;
        set_instr(5'd2, 32'h66, 5'd2, 5'd3, 5'd11, 4'b1010, 32'd4);
        va = 1'b1;
        step();
        va = 1'b0;
        check_a("t5.frz1", 4'd2, 32'h55, 5'd10, 4'b1011);
        step();
        check_a("t5.frz2", 4'd2, 32'h55, 5'd10, 4'b1011);
        step();
        check_a("t5.frz3", 4'd2, 32'h55, 5'd10, 4'b1011);
        stall = 1'b0;
        step();
        check_a("t5.thr3", 4'd3, 32'h55, 5'd10, 4'b1011);
        for (int t = 0; t < 4; t++) begin
            step();
            check_a($sformatf("t5.pushed%0d", t), 4'(t), 32'h66, 5'd11, 4'b1010);
        end
        step();
        check("t5.bubble", 32'(a_is_int), 32'd0);

        // 6: fill the buffer under stall, then 16 in-order issues
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t6.ready%0d", k), 32'(a_ready), 32'd1);
            set_instr(5'd1, 32'h100 + 32'(k), 5'd1, 5'd2, 5'(12 + k), 4'b1010, 32'(k));
            va = 1'b1;
            step();
        end
        va = 1'b0;
        check("t6.full", 32'(a_ready), 32'd0);
        stall = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            check_a($sformatf("t6.seq%0d", i), 4'(i % 4), 32'h100 + 32'(i / 4), 5'(12 + i / 4), 4'b1010);
        end
        step();
        check("t6.end_bubble", 32'(a_is_int), 32'd0);
        check("t6.end_ready", 32'(a_ready), 32'd1);
        check("t6.hb", a_hb, 32'd0);

        // 6b: refill, reset after the 7th issue
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_instr(5'd1, 32'h200 + 32'(k), 5'd1, 5'd2, 5'(20 + k), 4'b1010, 32'd0);
            va = 1'b1;
            step();
        end
        va = 1'b0;
        stall = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            check_a($sformatf("t6b.seq%0d", i), 4'(i % 4), 32'h200 + 32'(i / 4), 5'(20 + i / 4), 4'b1010);
        end
        reset = 1'b1;
        step();
        check_a("t6b.rst", 4'd0, 32'd0, 5'd0, 4'b0000);
        check("t6b.rst_busy", 32'(a_busy), 32'd0);
        check("t6b.rst_ready", 32'(a_ready), 32'd0);
        check("t6b.rst_hb_b", b_hb, 32'd0);
        reset = 1'b0;
        step();
        check("t6b.ready", 32'(a_ready), 32'd1);
        check("t6b.busy", 32'(a_busy), 32'd0);
        step();
        check("t6b.flushed", 32'({a_is_int, a_is_float, a_we3, a_pred_en}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
